// File: rtl/pl_ex_pkg.sv
// Shared constants and types for the RV32 execute stage: ALU op codes, branch and
// RV32M funct3 codes, forwarding selects and the mul/div sequencer states.
package pl_ex_pkg;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_OR    = 4'h3;
   localparam logic [3:0] ALU_XOR   = 4'h4;
   localparam logic [3:0] ALU_SLT   = 4'h5;
   localparam logic [3:0] ALU_SLTU  = 4'h6;
   localparam logic [3:0] ALU_SLL   = 4'h7;
   localparam logic [3:0] ALU_SRL   = 4'h8;
   localparam logic [3:0] ALU_SRA   = 4'h9;
   localparam logic [3:0] ALU_LUI   = 4'hA;
   localparam logic [3:0] ALU_AUIPC = 4'hB;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   localparam logic [1:0] FWD_RD = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

   function automatic logic isMulDiv(input logic [31:0] instr);
      return (instr[6:0] == OPC_OP) && (instr[31:25] == FUNCT7_M);
   endfunction

endpackage

// File: rtl/pl_stage_ex_if.sv
// Decode|execute register outputs into the execute stage and the stage's results
// towards memory, fetch and the hazard unit.
interface pl_stage_ex_if;

   logic        KillE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] PCE;
   logic [31:0] ImmExtE;
   logic [31:0] PCPlus4E;
   logic [31:0] InstrE;
   logic [3:0]  ALUControlE;
   logic        ALUSrcE;
   logic        JumpE;
   logic        BranchE;
   logic        JalrE;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic [31:0] ResultW;
   logic [31:0] ALUResultM;

   logic [31:0] ALUResultE;
   logic [31:0] WriteDataE;
   logic [31:0] PCTargetE;
   logic        PCSrcE;
   logic        StallMD;

   modport master (
      output KillE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, InstrE, ALUControlE,
             ALUSrcE, JumpE, BranchE, JalrE, ForwardAE, ForwardBE, ResultW, ALUResultM,
      input  ALUResultE, WriteDataE, PCTargetE, PCSrcE, StallMD
   );

   modport slave (
      input  KillE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, InstrE, ALUControlE,
             ALUSrcE, JumpE, BranchE, JalrE, ForwardAE, ForwardBE, ResultW, ALUResultM,
      output ALUResultE, WriteDataE, PCTargetE, PCSrcE, StallMD
   );

endinterface

// File: rtl/pl_muldiv_iter.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider on operand
// magnitudes with a sign fix-up at the end. Only built when PL_EX_MULDIV_EN is defined.
`ifdef PL_EX_MULDIV_EN
module pl_muldiv_iter
   import pl_ex_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int MD_BITS_ITER = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] srcA_i,
   input  logic [XLEN-1:0] srcB_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int ITERS = XLEN / MD_BITS_ITER;
   localparam int CW    = $clog2(ITERS + 1);

   md_state_t         state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   opB_q, opB_d;
   logic [XLEN-1:0]   dividend_q, dividend_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              negRes_q, negRes_d;
   logic              negRem_q, negRem_d;
   logic              divZero_q, divZero_d;

   logic              aSigned, bSigned, aNeg, bNeg;
   logic [XLEN-1:0]   aMag, bMag;
   logic [2*XLEN-1:0] stepAcc, stepMcand;
   logic [XLEN-1:0]   stepOpB;
   logic [XLEN:0]     divTmp;
   logic [XLEN+1:0]   divDiff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   assign aSigned = (funct3_i != M_MULHU) && (funct3_i != M_DIVU) && (funct3_i != M_REMU);
   assign bSigned = (funct3_i == M_MUL) || (funct3_i == M_MULH) ||
                    (funct3_i == M_DIV) || (funct3_i == M_REM);
   assign aNeg    = aSigned & srcA_i[XLEN-1];
   assign bNeg    = bSigned & srcB_i[XLEN-1];
   assign aMag    = aNeg ? -srcA_i : srcA_i;
   assign bMag    = bNeg ? -srcB_i : srcB_i;

   // One cycle of work: MD_BITS_ITER multiply (add/shift) or divide (trial subtract) steps.
   always_comb begin
      stepAcc   = acc_q;
      stepMcand = mcand_q;
      stepOpB   = opB_q;
      divTmp    = '0;
      divDiff   = '0;
      for (int k = 0; k < MD_BITS_ITER; k++) begin
         if (funct3_q[2]) begin
            divTmp  = stepAcc[2*XLEN-1:XLEN-1];
            divDiff = {1'b0, divTmp} - {2'b00, stepOpB};
            if (!divDiff[XLEN+1]) begin
               stepAcc = {divDiff[XLEN-1:0], stepAcc[XLEN-2:0], 1'b1};
            end else begin
               stepAcc = {divTmp[XLEN-1:0], stepAcc[XLEN-2:0], 1'b0};
            end
         end else begin
            if (stepOpB[0]) begin
               stepAcc = stepAcc + stepMcand;
            end
            stepMcand = stepMcand << 1;
            stepOpB   = stepOpB >> 1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      opB_d      = opB_q;
      dividend_d = dividend_q;
      funct3_d   = funct3_q;
      negRes_d   = negRes_q;
      negRem_d   = negRem_q;
      divZero_d  = divZero_q;
      case (state_q)
         IDLE: begin
            if (start_i && !kill_i) begin
               state_d    = RUN;
               count_d    = CW'(ITERS);
               acc_d      = funct3_i[2] ? {{XLEN{1'b0}}, aMag} : '0;
               mcand_d    = {{XLEN{1'b0}}, aMag};
               opB_d      = bMag;
               dividend_d = srcA_i;
               funct3_d   = funct3_i;
               negRes_d   = aNeg ^ bNeg;
               negRem_d   = aNeg;
               divZero_d  = (srcB_i == '0);
            end
         end
         RUN: begin
            acc_d   = stepAcc;
            mcand_d = stepMcand;
            opB_d   = stepOpB;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill_i) begin
         state_d = IDLE;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         opB_q      <= '0;
         dividend_q <= '0;
         funct3_q   <= '0;
         negRes_q   <= 1'b0;
         negRem_q   <= 1'b0;
         divZero_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         opB_q      <= opB_d;
         dividend_q <= dividend_d;
         funct3_q   <= funct3_d;
         negRes_q   <= negRes_d;
         negRem_q   <= negRem_d;
         divZero_q  <= divZero_d;
      end
   end

   // Divide by zero bypasses the sign fix-up: quotient all ones, remainder = raw dividend.
   assign prod = negRes_q ? -acc_q : acc_q;
   assign quo  = negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem  = negRem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      result_o = '0;
      case (funct3_q)
         M_MUL:                     result_o = prod[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: result_o = prod[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:             result_o = divZero_q ? '1 : quo;
         default:                   result_o = divZero_q ? dividend_q : rem;
      endcase
   end

   assign done_o = (state_q == DONE);

endmodule
`endif

// File: rtl/pl_stage_ex.sv
// RV32 execute stage: forwarding muxes, ALU, branch/jump resolution and, when
// PL_EX_MULDIV_EN is defined, the iterative RV32M unit that stalls the pipeline.
module pl_stage_ex
   import pl_ex_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int MD_BITS_ITER = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   pl_stage_ex_if.slave ex
);

   logic [31:0] srcA, srcB, writeData, aluRes;
   logic        taken, mOp;
   logic        unusedBits;

   function automatic logic [31:0] fwdSel(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] resW, input logic [31:0] aluM);
      case (sel)
         FWD_W:   return resW;
         FWD_M:   return aluM;
         default: return rd;
      endcase
   endfunction

   assign srcA      = fwdSel(ex.ForwardAE, ex.RD1E, ex.ResultW, ex.ALUResultM);
   assign writeData = fwdSel(ex.ForwardBE, ex.RD2E, ex.ResultW, ex.ALUResultM);
   assign srcB      = ex.ALUSrcE ? ex.ImmExtE : writeData;
   assign mOp       = isMulDiv(ex.InstrE);

   always_comb begin
      aluRes = '0;
      case (ex.ALUControlE)
         ALU_ADD:   aluRes = srcA + srcB;
         ALU_SUB:   aluRes = srcA - srcB;
         ALU_AND:   aluRes = srcA & srcB;
         ALU_OR:    aluRes = srcA | srcB;
         ALU_XOR:   aluRes = srcA ^ srcB;
         ALU_SLT:   aluRes = {31'b0, $signed(srcA) < $signed(srcB)};
         ALU_SLTU:  aluRes = {31'b0, srcA < srcB};
         ALU_SLL:   aluRes = srcA << srcB[4:0];
         ALU_SRL:   aluRes = srcA >> srcB[4:0];
         ALU_SRA:   aluRes = $unsigned($signed(srcA) >>> srcB[4:0]);
         ALU_LUI:   aluRes = srcB;
         ALU_AUIPC: aluRes = ex.PCE + ex.ImmExtE;
         default:   aluRes = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (ex.InstrE[14:12])
         BR_EQ:   taken = (srcA == srcB);
         BR_NE:   taken = (srcA != srcB);
         BR_LT:   taken = ($signed(srcA) < $signed(srcB));
         BR_GE:   taken = ($signed(srcA) >= $signed(srcB));
         BR_LTU:  taken = (srcA < srcB);
         BR_GEU:  taken = (srcA >= srcB);
         default: taken = 1'b0;
      endcase
   end

   assign ex.WriteDataE = writeData;
   assign ex.PCSrcE     = ex.JumpE | (ex.BranchE & taken);
   assign ex.PCTargetE  = ex.JalrE ? ((srcA + ex.ImmExtE) & ~32'd1) : (ex.PCE + ex.ImmExtE);

   // PC+4 and the register-index fields travel past this stage untouched.
   assign unusedBits = &{1'b0, ex.PCPlus4E, ex.InstrE[24:15], ex.InstrE[11:7]};

`ifdef PL_EX_MULDIV_EN
   logic        mdDone;
   logic [31:0] mdResult;

   pl_muldiv_iter #(
      .XLEN         (XLEN),
      .MD_BITS_ITER (MD_BITS_ITER)
   ) u_md (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mOp),
      .kill_i   (ex.KillE),
      .funct3_i (ex.InstrE[14:12]),
      .srcA_i   (srcA),
      .srcB_i   (srcB),
      .done_o   (mdDone),
      .result_o (mdResult)
   );

   assign ex.StallMD    = mOp & ~mdDone;
   assign ex.ALUResultE = mdDone ? mdResult : aluRes;
`else
   logic unusedCfg;

   assign unusedCfg     = &{1'b0, clk, rst_n, ex.KillE, (XLEN == 32), (MD_BITS_ITER > 0)};
   assign ex.StallMD    = 1'b0;
   assign ex.ALUResultE = mOp ? 32'd0 : aluRes;
`endif

endmodule
